// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the buffered UART transmitter: FSM encoding, frame width,
// SOC register addresses and the baud divisor helper.
package uart_tx_fifo_pkg;

    localparam int UART_DATA_BITS = 8;

    // TX data / status register addresses, consumed by the SOC address decode
    localparam logic [31:0] UART_TX_DATA_ADDR   = 32'h4000_0000;
    localparam logic [31:0] UART_TX_STATUS_ADDR = 32'h4000_0004;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    function automatic int calc_clks_per_bit(input int clk_hz, input int baud);
        return clk_hz / baud;
    endfunction

endpackage

// File: rtl/uart_tx_fifo_if.sv
// Write-side bus between the CPU store path (master) and the UART TX block (slave).
interface uart_tx_fifo_if
    import uart_tx_fifo_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) ();
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic                      wr_en;
    logic [UART_DATA_BITS-1:0] wr_data;
    logic                      full;
    logic [CW-1:0]             count;
    logic                      busy;
    logic                      overflow;

    modport master (output wr_en, wr_data, input full, count, busy, overflow);
    modport slave  (input wr_en, wr_data, output full, count, busy, overflow);

endinterface

// File: rtl/uart_tx_fifo_sync_fifo.sv
// Single-clock byte FIFO with registered occupancy count, full flag and sticky overflow.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push_req,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       overflow
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic [CW-1:0]    count_nxt_s;
    logic             full_r;
    logic             overflow_r;
    logic             accept_s;

    // Full is the flag registered on the previous edge, so a pop cannot rescue a push into a full FIFO
    assign accept_s = push_req && !full_r;

    // Occupancy update for push, pop, or both at once
    always_comb begin
        count_nxt_s = count_r;
        case ({accept_s, pop})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage array; contents need no reset because the pointers define validity
    always_ff @(posedge clk) begin
        if (accept_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, occupancy, full flag and sticky overflow
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r   <= '0;
            rd_ptr_r   <= '0;
            count_r    <= '0;
            full_r     <= 1'b0;
            overflow_r <= 1'b0;
        end else begin
            if (accept_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            count_r <= count_nxt_s;
            full_r  <= (count_nxt_s == CW'(DEPTH));
            if (push_req && full_r) begin
                overflow_r <= 1'b1;
            end
        end
    end

    assign dout     = mem_r[rd_ptr_r];
    assign count    = count_r;
    assign full     = full_r;
    assign overflow = overflow_r;

endmodule

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: queued bytes are serialised LSB-first onto TXD,
// with back-to-back frames whenever the queue is non-empty at the end of a stop bit.
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50_000_000,
    parameter int BAUD        = 115200,
    parameter int FIFO_DEPTH  = 8
) (
    input  logic                 clk,
    input  logic                 RST,
    uart_tx_fifo_if.slave        bus,
    output logic                 TXD
);
    localparam int          CLKS_PER_BIT = calc_clks_per_bit(CLK_FREQ_HZ, BAUD);
    localparam int          BW           = $clog2(CLKS_PER_BIT);
    localparam int          CW           = $clog2(FIFO_DEPTH) + 1;
    localparam logic [2:0]  LAST_BIT     = 3'(UART_DATA_BITS - 1);

    tx_state_e                 state_r, state_nxt_s;
    logic [BW-1:0]             baud_r, baud_nxt_s;
    logic [2:0]                bit_idx_r, bit_idx_nxt_s;
    logic [UART_DATA_BITS-1:0] shift_r, shift_nxt_s;
    logic                      txd_r, txd_nxt_s;
    logic                      pop_s;
    logic                      bit_tick_s;
    logic                      has_data_s;
    logic [UART_DATA_BITS-1:0] fifo_dout_s;
    logic [CW-1:0]             fifo_count_s;

    sync_fifo #(
        .WIDTH (UART_DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst      (RST),
        .push_req (bus.wr_en),
        .pop      (pop_s),
        .din      (bus.wr_data),
        .dout     (fifo_dout_s),
        .count    (fifo_count_s),
        .full     (bus.full),
        .overflow (bus.overflow)
    );

    assign bit_tick_s = (baud_r == BW'(CLKS_PER_BIT - 1));
    assign has_data_s = (fifo_count_s != CW'(0));

    // State and datapath registers; reset drops the line back to idle immediately
    always_ff @(posedge clk) begin
        if (RST) begin
            state_r   <= ST_IDLE;
            baud_r    <= '0;
            bit_idx_r <= 3'd0;
            shift_r   <= '0;
            txd_r     <= 1'b1;
        end else begin
            state_r   <= state_nxt_s;
            baud_r    <= baud_nxt_s;
            bit_idx_r <= bit_idx_nxt_s;
            shift_r   <= shift_nxt_s;
            txd_r     <= txd_nxt_s;
        end
    end

    // Frame sequencing
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:  state_nxt_s = has_data_s ? ST_START : ST_IDLE;
            ST_START: state_nxt_s = bit_tick_s ? ST_DATA : ST_START;
            ST_DATA:  state_nxt_s = (bit_tick_s && (bit_idx_r == LAST_BIT)) ? ST_STOP : ST_DATA;
            ST_STOP: begin
                if (bit_tick_s) begin
                    state_nxt_s = has_data_s ? ST_START : ST_IDLE;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default:  state_nxt_s = ST_IDLE;
        endcase
    end

    // Bit timing, shifter, next line level and FIFO pop
    always_comb begin
        pop_s         = 1'b0;
        baud_nxt_s    = bit_tick_s ? BW'(0) : baud_r + BW'(1);
        bit_idx_nxt_s = bit_idx_r;
        shift_nxt_s   = shift_r;
        txd_nxt_s     = txd_r;
        case (state_r)
            ST_IDLE: begin
                baud_nxt_s = BW'(0);
                if (has_data_s) begin
                    pop_s       = 1'b1;
                    shift_nxt_s = fifo_dout_s;
                    txd_nxt_s   = 1'b0;
                end else begin
                    txd_nxt_s   = 1'b1;
                end
            end
            ST_START: begin
                if (bit_tick_s) begin
                    txd_nxt_s     = shift_r[0];
                    bit_idx_nxt_s = 3'd0;
                end else begin
                    txd_nxt_s     = txd_r;
                end
            end
            ST_DATA: begin
                if (bit_tick_s && (bit_idx_r == LAST_BIT)) begin
                    txd_nxt_s = 1'b1;
                end else if (bit_tick_s) begin
                    // shift_r[0] is already on the line, so the next bit is shift_r[1]
                    txd_nxt_s     = shift_r[1];
                    shift_nxt_s   = {1'b0, shift_r[UART_DATA_BITS-1:1]};
                    bit_idx_nxt_s = bit_idx_r + 3'd1;
                end else begin
                    txd_nxt_s = txd_r;
                end
            end
            ST_STOP: begin
                if (bit_tick_s && has_data_s) begin
                    pop_s       = 1'b1;
                    shift_nxt_s = fifo_dout_s;
                    txd_nxt_s   = 1'b0;
                end else begin
                    txd_nxt_s   = 1'b1;
                end
            end
            default: begin
                baud_nxt_s = BW'(0);
                txd_nxt_s  = 1'b1;
            end
        endcase
    end

    assign TXD      = txd_r;
    assign bus.busy = (state_r != ST_IDLE) || has_data_s;
    assign bus.count = fifo_count_s;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Self-checking bench for uart_tx_fifo: a queue-and-frame-position model checked every
// cycle, a line decoder, and directed scenarios with hand-computed expectations.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 8;
    localparam int FRAME = 10 * CPB;

    logic clk;
    logic rst;
    logic txd;

    uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus ();

    uart_tx_fifo #(
        .CLK_FREQ_HZ (16),
        .BAUD        (4),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk (clk),
        .RST (rst),
        .bus (bus),
        .TXD (txd)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    // behavioural model: pending bytes, frame in flight and its position in clock cycles
    logic [7:0] m_q[$];
    bit         m_active = 1'b0;
    int         m_pos    = 0;
    logic [7:0] m_byte   = 8'h00;
    bit         m_ovf    = 1'b0;
    int         m_pre;

    logic [7:0] rx_q[$];
    bit         mon_act = 1'b0;
    int         mon_cnt = 0;
    logic [7:0] mon_byte = 8'h00;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic exp_txd();
        int k;
        if (!m_active) return 1'b1;
        k = m_pos / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return m_byte[k-1];
        return 1'b1;
    endfunction

    // model update at each active edge
    always @(posedge clk) begin
        if (rst === 1'b1) begin
            m_q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_ovf    = 1'b0;
        end else begin
            m_pre = m_q.size();
            if (!m_active) begin
                if (m_pre != 0) begin
                    m_byte   = m_q.pop_front();
                    m_active = 1'b1;
                    m_pos    = 0;
                end
            end else begin
                m_pos++;
                if (m_pos == FRAME) begin
                    if (m_pre != 0) begin
                        m_byte = m_q.pop_front();
                        m_pos  = 0;
                    end else begin
                        m_active = 1'b0;
                    end
                end
            end
            if (bus.wr_en === 1'b1) begin
                if (m_pre == DEPTH) m_ovf = 1'b1;
                else m_q.push_back(bus.wr_data);
            end
        end
    end

    // every-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("txd",      32'(txd),          32'(exp_txd()));
            chk("count",    32'(bus.count),    32'(m_q.size()));
            chk("full",     32'(bus.full),     32'(m_q.size() == DEPTH));
            chk("busy",     32'(bus.busy),     32'(m_active || (m_q.size() != 0)));
            chk("overflow", 32'(bus.overflow), 32'(m_ovf));
        end
    end

    // line decoder: mid-bit sampling from the first low half-cycle
    always @(negedge clk) begin
        if (rst !== 1'b0 || !chk_en) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (txd === 1'b0) begin
                mon_act = 1'b1;
                mon_cnt = 0;
            end
        end else begin
            mon_cnt++;
            if (mon_cnt == 2) chk("start_bit", 32'(txd), 32'd0);
            if (mon_cnt >= 6 && mon_cnt <= 34 && ((mon_cnt - 6) % 4) == 0)
                mon_byte[(mon_cnt - 6) / 4] = txd;
            if (mon_cnt == 38) chk("stop_bit", 32'(txd), 32'd1);
            if (mon_cnt == 39) begin
                rx_q.push_back(mon_byte);
                mon_act = 1'b0;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic wait_rx(input int n, input int budget);
        int c = 0;
        while (rx_q.size() < n && c < budget) begin
            step();
            c++;
        end
        chk("rx_timeout", 32'(rx_q.size() >= n), 32'd1);
    endtask

    task automatic wait_idle(input int budget);
        int c = 0;
        while (bus.busy !== 1'b0 && c < budget) begin
            step();
            c++;
        end
        chk("idle_timeout", 32'(bus.busy), 32'd0);
    endtask

    task automatic expect_rx(input string name, input logic [7:0] exp);
        logic [7:0] got;
        got = (rx_q.size() != 0) ? rx_q.pop_front() : 8'hxx;
        chk(name, 32'(got), 32'(exp));
    endtask

    initial begin
        rst         = 1'b1;
        bus.wr_en   = 1'b0;
        bus.wr_data = 8'h00;
        repeat (3) @(posedge clk);
        #2;
        rst    = 1'b0;
        chk_en = 1'b1;

        // 1: reset values, then a quiet line
        chk("rst_txd",  32'(txd),          32'd1);
        chk("rst_count",32'(bus.count),    32'd0);
        chk("rst_busy", 32'(bus.busy),     32'd0);
        chk("rst_ovf",  32'(bus.overflow), 32'd0);
        chk("rst_full", 32'(bus.full),     32'd0);
        repeat (20) step();

        // 2: single byte, launch latency of two edges
        bus.wr_en = 1'b1; bus.wr_data = 8'h55;
        step();
        bus.wr_en = 1'b0;
        chk("t2_edge1_txd",   32'(txd),       32'd1);
        chk("t2_edge1_count", 32'(bus.count), 32'd1);
        step();
        chk("t2_edge2_txd",   32'(txd),       32'd0);
        chk("t2_edge2_count", 32'(bus.count), 32'd0);
        wait_rx(1, 60);
        expect_rx("t2_byte", 8'h55);
        wait_idle(20);

        // 3: two consecutive writes, back-to-back frames
        bus.wr_en = 1'b1; bus.wr_data = 8'hA3;
        step();
        chk("t3_count_a", 32'(bus.count), 32'd1);
        bus.wr_data = 8'h0F;
        step();
        bus.wr_en = 1'b0;
        chk("t3_count_b", 32'(bus.count), 32'd1);
        repeat (FRAME - 1) step();
        chk("t3_stop_txd",   32'(txd),       32'd1);
        chk("t3_stop_count", 32'(bus.count), 32'd1);
        step();
        chk("t3_restart_txd",   32'(txd),       32'd0);
        chk("t3_restart_count", 32'(bus.count), 32'd0);
        wait_rx(2, 100);
        expect_rx("t3_byte0", 8'hA3);
        expect_rx("t3_byte1", 8'h0F);
        wait_idle(60);

        // 4: ten pushes without gaps, the tenth is dropped
        for (int i = 0; i < 10; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'hC0 + 8'(i);
            step();
        end
        bus.wr_en = 1'b0;
        chk("t4_full",  32'(bus.full),     32'd1);
        chk("t4_count", 32'(bus.count),    32'd8);
        chk("t4_ovf",   32'(bus.overflow), 32'd1);
        wait_rx(9, 9 * FRAME + 50);
        for (int i = 0; i < 9; i++) expect_rx("t4_byte", 8'hC0 + 8'(i));
        wait_idle(60);
        chk("t4_no_tenth", 32'(rx_q.size()), 32'd0);
        chk("t4_ovf_sticky", 32'(bus.overflow), 32'd1);

        // 5: reset in the third data bit of 0xFF with three bytes queued
        bus.wr_en = 1'b1; bus.wr_data = 8'hFF;
        step();
        bus.wr_data = 8'h11; step();
        bus.wr_data = 8'h22; step();
        bus.wr_data = 8'h33; step();
        bus.wr_en = 1'b0;
        chk("t5_count", 32'(bus.count), 32'd3);
        repeat (10) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_txd",   32'(txd),          32'd1);
        chk("t5_count0",32'(bus.count),    32'd0);
        chk("t5_busy",  32'(bus.busy),     32'd0);
        chk("t5_ovf",   32'(bus.overflow), 32'd0);
        chk("t5_no_partial", 32'(rx_q.size()), 32'd0);
        bus.wr_en = 1'b1; bus.wr_data = 8'h81;
        step();
        bus.wr_en = 1'b0;
        wait_rx(1, 60);
        expect_rx("t5_byte", 8'h81);
        wait_idle(20);

        // 6: push into a full FIFO on the same edge as the stop-to-start pop
        for (int i = 0; i < 9; i++) begin
            bus.wr_en = 1'b1; bus.wr_data = 8'h60 + 8'(i);
            step();
        end
        bus.wr_en = 1'b0;
        chk("t6_full_pre",  32'(bus.full),  32'd1);
        chk("t6_count_pre", 32'(bus.count), 32'd8);
        repeat (32) step();
        chk("t6_count_edge", 32'(bus.count),    32'd8);
        chk("t6_ovf_edge",   32'(bus.overflow), 32'd0);
        chk("t6_txd_stop",   32'(txd),          32'd1);
        bus.wr_en = 1'b1; bus.wr_data = 8'hEE;
        step();
        bus.wr_en = 1'b0;
        chk("t6_count_post", 32'(bus.count),    32'd7);
        chk("t6_ovf_post",   32'(bus.overflow), 32'd1);
        chk("t6_full_post",  32'(bus.full),     32'd0);
        chk("t6_txd_start",  32'(txd),          32'd0);
        wait_rx(9, 9 * FRAME + 50);
        for (int i = 0; i < 9; i++) expect_rx("t6_byte", 8'h60 + 8'(i));
        wait_idle(60);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
